mem_trace_fifo: RTL and testbench
=================================

// Module: mem_trace_fifo
// PURPOSE
//  Downstream capture stage for the core's data-memory trace outputs (wr, rd, addr, wr_data, rd_data).
//  Every cycle with wr or rd high becomes one record: access type, address, data word and a cycle timestamp.
//  Records are buffered in a DEPTH-entry FIFO and drained over a valid/ready port to a bench monitor or debug link.
//  Overflow drops records, never stalls the core; drops are counted.
// PARAMETERS
//  DATA_W  32  width of wr_data/rd_data and out_data
//  ADDR_W  9   width of addr and out_addr
//  DEPTH   16  FIFO entries; power of two, >=2
//  TS_W    16  timestamp counter width
// PORTS
//  clk        in   1              clock, rising edge
//  reset      in   1              asynchronous, active-low reset
//  clear      in   1              sync flush: FIFO, timestamp, drop counter, overflow
//  wr         in   1              core data-memory write strobe, this cycle
//  rd         in   1              core data-memory read strobe, this cycle
//  addr       in   ADDR_W         memory word address of the access
//  wr_data    in   DATA_W         store data
//  rd_data    in   DATA_W         load data
//  out_valid  out  1              head record present
//  out_ready  in   1              consumer accepts head this cycle
//  out_type   out  2              {wr,rd} of head record: 10 store, 01 load, 11 both
//  out_addr   out  ADDR_W         head record address
//  out_data   out  DATA_W         head record data
//  out_ts     out  TS_W           head record timestamp
//  count      out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow   out  1              sticky: at least one record dropped
//  drop_cnt   out  8              dropped records, saturates at 255
// BEHAVIOUR
//  Reset (reset low, async): pointers=0, count=0, out_valid=0, ts=0, drop_cnt=0, overflow=0.
//   out_type/addr/data/ts read 0 while empty. Storage array need not be reset.
//  Timestamp: free-running TS_W counter, +1 every cycle, wraps to 0. Record ts = value in the capture cycle.
//  Push = wr|rd. Record data = wr ? wr_data : rd_data (11 stores wr_data).
//  Pop = out_valid & out_ready. Head is registered storage, no bypass.
//   A push to an empty FIFO shows out_valid=1 the next cycle (latency 1).
//  out_* held stable while out_valid & !out_ready.
//  Full (count==DEPTH), push, no pop: record dropped; overflow<=1; drop_cnt+1 (sat 255).
//  Full, push and pop together: both take effect; count stays DEPTH; no drop.
//  Empty, pop: impossible (out_valid=0). Empty with push: count 0->1.
//  Pointers are log2(DEPTH) bits and wrap naturally; count tracks full vs empty.
//  clear: highest priority. Pointers, count, ts, drop_cnt and overflow go to 0 next cycle.
//   A same-cycle push or pop is discarded.
//  Reset asserted mid-drain: immediate return to reset state. No partial record survives.
// TESTING
//  1. reset low then high; wr=1 addr=0x004 wr_data=0xDEADBEEF for 1 cycle
//     -> next cycle out_valid=1 type=10 addr=0x004 data=0xDEADBEEF count=1.
//  2. rd=1 for DEPTH+3 cycles with out_ready=0
//     -> count=16, overflow=1, drop_cnt=3; first 16 records in order, ts consecutive.
//  3. Full FIFO, push and out_ready=1 every cycle for 20 cycles
//     -> no drops, count stays 16, output order matches input order.
//  4. wr=rd=1, wr_data=0x11, rd_data=0x22 -> record type=11 data=0x11.
//  5. 10 entries held, clear=1 together with wr=1 -> next cycle count=0, out_valid=0, ts=0, overflow=0.
//  6. reset low mid-drain -> out_valid=0 and count=0 asynchronously;
//     after release, ts restarts at 0 and the FIFO works normally.

Source files
------------

// File: rtl/mem_trace_fifo_if.sv
// ============================================================================
// mem_trace_fifo_if : trace capture inputs and record drain port   (rev 1.0)
// ============================================================================
`default_nettype none

interface mem_trace_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int TS_W   = 16
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_type;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;

  modport master (
    output wr, rd, addr, wr_data, rd_data, out_ready,
    input  out_valid, out_type, out_addr, out_data, out_ts
  );

  modport slave (
    input  wr, rd, addr, wr_data, rd_data, out_ready,
    output out_valid, out_type, out_addr, out_data, out_ts
  );
endinterface

`default_nettype wire

// File: rtl/mem_trace_fifo.sv
// ============================================================================
// mem_trace_fifo : timestamped data-memory trace capture FIFO, drop-on-full
// rev 1.0
// ============================================================================
`default_nettype none

module mem_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  mem_trace_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 2 + ADDR_W + DATA_W + TS_W;

  logic [REC_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  logic             drop;
  logic             valid;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] head;

  always_comb begin
    valid  = (count_q != '0);
    full   = (count_q == CNT_W'(DEPTH));
    push   = (bus.wr | bus.rd) & ~clear;
    pop    = valid & bus.out_ready & ~clear;
    // A full FIFO still accepts when the head leaves in the same cycle.
    accept = push & (~full | pop);
    drop   = push & full & ~pop;
    rec_in = {bus.wr, bus.rd, bus.addr, (bus.wr ? bus.wr_data : bus.rd_data), ts_q};

    wr_ptr_d   = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
    ts_d       = ts_q + TS_W'(1);
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ts_d       = '0;
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  always_comb begin
    head          = valid ? mem_q[rd_ptr_q] : '0;
    bus.out_valid = valid;
    bus.out_type  = head[REC_W-1 -: 2];
    bus.out_addr  = head[REC_W-3 -: ADDR_W];
    bus.out_data  = head[TS_W +: DATA_W];
    bus.out_ts    = head[TS_W-1:0];
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_trace_fifo.sv
// ============================================================================
// tb_mem_trace_fifo : scoreboard bench for mem_trace_fifo   (rev 1.0)
// ============================================================================
`default_nettype none

module tb_mem_trace_fifo;

  typedef struct packed {
    logic [1:0]  t;
    logic [8:0]  a;
    logic [31:0] d;
    logic [15:0] ts;
  } rec_t;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int   errors = 0;
  int   checks = 0;
  rec_t exp_q[$];
  int   mcount = 0;
  logic [15:0] ts_m = '0;

  mem_trace_fifo_if #(.DATA_W(32), .ADDR_W(9), .TS_W(16)) bus ();

  mem_trace_fifo #(.DATA_W(32), .ADDR_W(9), .DEPTH(16), .TS_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops the oldest expected record.
  initial begin
    rec_t e;
    rec_t act;
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid && bus.out_ready) begin
        act = '{t: bus.out_type, a: bus.out_addr, d: bus.out_data, ts: bus.out_ts};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL record: got 0x%0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk("record", 64'(act), 64'(e));
        end
      end
    end
  end

  // One clock of stimulus; expected records go to the scoreboard queue.
  task automatic cycle(input logic w, input logic r, input logic [8:0] a,
                       input logic [31:0] wd, input logic [31:0] rdd,
                       input logic rdy, input logic clr);
    logic pop_m;
    logic acc;
    bus.wr = w; bus.rd = r; bus.addr = a; bus.wr_data = wd; bus.rd_data = rdd;
    bus.out_ready = rdy; clear = clr;
    pop_m = (mcount != 0) && rdy && !clr;
    if (clr) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      acc = (w | r) && ((mcount < 16) || pop_m);
      if (acc) exp_q.push_back('{t: {w, r}, a: a, d: (w ? wd : rdd), ts: ts_m});
      mcount = mcount + int'(acc) - int'(pop_m);
    end
    @(posedge clk);
    #1;
    ts_m = clr ? 16'd0 : ts_m + 16'd1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 9'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clear = 1'b0;
    bus.wr = 0; bus.rd = 0; bus.addr = '0; bus.wr_data = '0; bus.rd_data = '0;
    bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_fields", {bus.out_type, bus.out_addr, bus.out_data, bus.out_ts}, 64'd0);
    reset = 1'b1;
    ts_m = '0;

    // Single store, latency 1
    cycle(1'b1, 1'b0, 9'h004, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_type", 64'(bus.out_type), 64'd2);
    chk("t1_addr", 64'(bus.out_addr), 64'h004);
    chk("t1_data", 64'(bus.out_data), 64'hDEADBEEF);
    chk("t1_ts", 64'(bus.out_ts), 64'd0);
    chk("t1_count", 64'(count), 64'd1);
    idle(1'b1);
    chk("t1_drained", 64'(count), 64'd0);

    // Overfill with loads
    for (int i = 0; i < 19; i++) cycle(1'b0, 1'b1, 9'(i), 32'd0, 32'h100 + 32'(i), 1'b0, 1'b0);
    chk("t2_count", 64'(count), 64'd16);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_drop", 64'(drop_cnt), 64'd3);
    chk("t2_head_addr", 64'(bus.out_addr), 64'd0);
    chk("t2_head_ts", 64'(bus.out_ts), 64'd2);

    // Full with simultaneous push and pop
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 9'(i + 32), 32'h1000 + 32'(i), 32'd0, 1'b1, 1'b0);
    chk("t3_count", 64'(count), 64'd16);
    chk("t3_drop", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < 16; i++) idle(1'b1);
    chk("t3_drained", 64'(count), 64'd0);

    // Store and load in one cycle
    cycle(1'b1, 1'b1, 9'h055, 32'h11, 32'h22, 1'b0, 1'b0);
    chk("t4_type", 64'(bus.out_type), 64'd3);
    chk("t4_data", 64'(bus.out_data), 64'h11);
    idle(1'b1);

    // Clear wins over a same-cycle push
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 9'(i), 32'(i), 32'd0, 1'b0, 1'b0);
    chk("t5_count10", 64'(count), 64'd10);
    cycle(1'b1, 1'b0, 9'h1FF, 32'hBAD, 32'd0, 1'b0, 1'b1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_ovf", 64'(overflow), 64'd0);
    chk("t5_drop", 64'(drop_cnt), 64'd0);
    cycle(1'b0, 1'b1, 9'h007, 32'd0, 32'h77, 1'b0, 1'b0);
    chk("t5_ts", 64'(bus.out_ts), 64'd0);
    idle(1'b1);

    // Reset in the middle of a drain
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 9'(i + 100), 32'hA0 + 32'(i), 32'd0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    exp_q.delete();
    mcount = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ts_m = '0;
    cycle(1'b1, 1'b0, 9'h003, 32'hCAFE, 32'd0, 1'b0, 1'b0);
    chk("t6_ts", 64'(bus.out_ts), 64'd0);
    chk("t6_count1", 64'(count), 64'd1);
    idle(1'b1);
    idle(1'b0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
